// File: rtl/run_monitor_pkg.sv
// Shared types and defaults for the run monitor and the core it observes.
package run_monitor_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned NREGS_DEFAULT = 32;
  localparam int unsigned REG_X0        = 0;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StCheck,
    StDone
  } run_state_e;

endpackage

// File: rtl/run_monitor_halt_detector.sv
// Counts consecutive cycles of an unchanged PC; halted_o fires when the count reaches HALT_CYCLES.
module halt_detector #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned HALT_CYCLES = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            en_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            halted_o
);

  localparam int unsigned CW = $clog2(HALT_CYCLES + 1);

  logic [XLEN-1:0] prev_pc_q;
  logic            prev_vld_q;
  logic [CW-1:0]   stable_q, stable_d;
  logic            same;

  always_comb begin
    // The first enabled cycle after a clear has no valid previous PC to compare with.
    same     = prev_vld_q && (pc_i == prev_pc_q);
    stable_d = '0;
    if (same) begin
      stable_d = (stable_q == CW'(HALT_CYCLES)) ? stable_q : stable_q + 1'b1;
    end
    halted_o = en_i && (stable_d == CW'(HALT_CYCLES));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_pc_q  <= '0;
      prev_vld_q <= 1'b0;
      stable_q   <= '0;
    end else if (clear_i) begin
      prev_vld_q <= 1'b0;
      stable_q   <= '0;
    end else if (en_i) begin
      prev_pc_q  <= pc_i;
      prev_vld_q <= 1'b1;
      stable_q   <= stable_d;
    end
  end

endmodule

// File: rtl/run_monitor.sv
// Run monitor: shadows writebacks, detects halt/timeout, then checks registers against a table.
// Define RUN_MONITOR_MISMATCH_CAPTURE_EN to expose the first mismatching actual/expected values.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEFAULT,
  parameter int unsigned NREGS       = NREGS_DEFAULT,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MAX_CYCLES  = 1000,
  parameter int unsigned HALT_CYCLES = 4,
  localparam int unsigned AW         = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             wb_en_i,
  input  logic [AW-1:0]    wb_addr_i,
  input  logic [XLEN-1:0]  wb_data_i,
  input  logic             exp_we_i,
  input  logic [AW-1:0]    exp_addr_i,
  input  logic [XLEN-1:0]  exp_data_i,
  input  logic             exp_clr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [AW-1:0]    fail_idx_o,
`ifdef RUN_MONITOR_MISMATCH_CAPTURE_EN
  output logic [XLEN-1:0]  err_actual_o,
  output logic [XLEN-1:0]  err_expected_o,
`endif
  output logic [CNT_W-1:0] cycle_cnt_o
);

  run_state_e       state_q;
  logic [XLEN-1:0]  shadow_q [NREGS];
  logic [XLEN-1:0]  exp_q    [NREGS];
  logic [NREGS-1:0] flag_q;
  logic [AW-1:0]    idx_q;
  logic [AW-1:0]    fail_idx_q;
  logic             pass_q;
  logic             timeout_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] cycle_cnt_inc;
  logic             idle_or_done;
  logic             halted;
  logic             mismatch;
`ifdef RUN_MONITOR_MISMATCH_CAPTURE_EN
  logic [XLEN-1:0]  err_actual_q;
  logic [XLEN-1:0]  err_expected_q;
`endif

  assign idle_or_done  = (state_q == StIdle) || (state_q == StDone);
  assign cycle_cnt_inc = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
  assign mismatch      = flag_q[idx_q] && (shadow_q[idx_q] != exp_q[idx_q]);

  halt_detector #(
    .XLEN       (XLEN),
    .HALT_CYCLES(HALT_CYCLES)
  ) u_halt_detector (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (start_i && idle_or_done),
    .en_i    (state_q == StRun),
    .pc_i    (pc_i),
    .halted_o(halted)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      shadow_q       <= '{default: '0};
      exp_q          <= '{default: '0};
      flag_q         <= '0;
      idx_q          <= '0;
      fail_idx_q     <= '0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
      cycle_cnt_q    <= '0;
`ifdef RUN_MONITOR_MISMATCH_CAPTURE_EN
      err_actual_q   <= '0;
      err_expected_q <= '0;
`endif
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (exp_clr_i) begin
            flag_q <= '0;
          end else if (exp_we_i) begin
            exp_q[exp_addr_i]  <= exp_data_i;
            flag_q[exp_addr_i] <= 1'b1;
          end
          if (start_i) begin
            state_q        <= StRun;
            shadow_q       <= '{default: '0};
            cycle_cnt_q    <= '0;
            fail_idx_q     <= '0;
            pass_q         <= 1'b0;
            timeout_q      <= 1'b0;
`ifdef RUN_MONITOR_MISMATCH_CAPTURE_EN
            err_actual_q   <= '0;
            err_expected_q <= '0;
`endif
          end
        end
        StRun: begin
          cycle_cnt_q <= cycle_cnt_inc;
          if (wb_en_i && (wb_addr_i != AW'(REG_X0))) begin
            shadow_q[wb_addr_i] <= wb_data_i;
          end
          // Halt takes priority over a timeout landing on the same cycle.
          if (halted) begin
            state_q <= StCheck;
            idx_q   <= '0;
          end else if (cycle_cnt_inc >= CNT_W'(MAX_CYCLES)) begin
            state_q   <= StDone;
            timeout_q <= 1'b1;
          end
        end
        StCheck: begin
          if (mismatch) begin
            state_q        <= StDone;
            fail_idx_q     <= idx_q;
`ifdef RUN_MONITOR_MISMATCH_CAPTURE_EN
            err_actual_q   <= shadow_q[idx_q];
            err_expected_q <= exp_q[idx_q];
`endif
          end else if (idx_q == AW'(NREGS - 1)) begin
            state_q <= StDone;
            pass_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o         = (state_q == StRun) || (state_q == StCheck);
  assign done_o         = (state_q == StDone);
  assign pass_o         = pass_q;
  assign timeout_o      = timeout_q;
  assign fail_idx_o     = fail_idx_q;
  assign cycle_cnt_o    = cycle_cnt_q;
`ifdef RUN_MONITOR_MISMATCH_CAPTURE_EN
  assign err_actual_o   = err_actual_q;
  assign err_expected_o = err_expected_q;
`endif

endmodule
